// File: rtl/dac_mux_pkg.sv
// Shared types and constants for the DAC routing handshake (router + sequencer).
package dac_mux_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } seq_state_t;

  // Cycles o_addr_ready stays low so the router can leave WAIT_CLEAR.
  localparam int RELEASE_CYCLES = 2;

  localparam int DEF_VECTOR_SIZE = 4;

  function automatic int total_options(input int vector_size);
    return (vector_size * 2) + (vector_size * vector_size);
  endfunction

  localparam int DEF_TOTAL_OPTIONS = total_options(DEF_VECTOR_SIZE);

endpackage

// File: rtl/dac_addr_sequencer_if.sv
// Request (I2C side) and address/ack (router side) signals of the sequencer.
// master: the sequencer itself; slave: whoever feeds requests and acks.
interface dac_addr_sequencer_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_W      = 3
);
  logic                  i_req_valid;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic                  o_req_ready;
  logic [ADDR_WIDTH-1:0] o_addr_out;
  logic                  o_addr_ready;
  logic                  i_ack_in;
  logic                  o_done;
  logic                  o_timeout;
  logic                  o_err_addr;
  logic                  o_busy;
  logic [CNT_W-1:0]      o_fifo_count;

  modport master (
    input  i_req_valid, i_req_addr, i_ack_in,
    output o_req_ready, o_addr_out, o_addr_ready, o_done, o_timeout,
           o_err_addr, o_busy, o_fifo_count
  );

  modport slave (
    output i_req_valid, i_req_addr, i_ack_in,
    input  o_req_ready, o_addr_out, o_addr_ready, o_done, o_timeout,
           o_err_addr, o_busy, o_fifo_count
  );
endinterface

// File: rtl/dac_addr_fifo.sv
// Request queue: FIFO_DEPTH x ADDR_WIDTH, head visible combinationally on dout.
module dac_addr_fifo #(
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [ADDR_WIDTH-1:0]       din,
  output logic [ADDR_WIDTH-1:0]       dout,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  do_push, do_pop;

  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset: validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally (depth is a power of two); count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/dac_addr_sequencer.sv
// DAC address sequencer: queues line addresses and presents them one at a
// time to the router (ISSUE until ack, then a fixed RELEASE gap).
// Optional feature macro: DAC_SEQ_TIMEOUT_EN -- when defined, an ISSUE that
// sees no ack for TIMEOUT_CYCLES cycles is abandoned with an o_timeout pulse;
// when undefined, ISSUE waits forever and o_timeout stays 0.
module dac_addr_sequencer
  import dac_mux_pkg::*;
#(
  parameter int VECTOR_SIZE    = DEF_VECTOR_SIZE,
  parameter int TOTAL_OPTIONS  = total_options(VECTOR_SIZE),
  parameter int ADDR_WIDTH     = $clog2(TOTAL_OPTIONS),
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                i_clk,
  input  logic                i_rst,
  dac_addr_sequencer_if.master bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1)
  begin : g_bad_param
    $error("dac_addr_sequencer: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
  end

`ifdef DAC_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt;
`endif

  seq_state_t            state;
  logic [ADDR_WIDTH-1:0] addr_q, fifo_dout;
  logic                  addr_ready_q, done_q, timeout_q, err_q;
  logic [REL_W-1:0]      rel_cnt;
  logic                  in_range, accept, push, pop, full, empty;
  logic [CNT_W-1:0]      count;

  // Out-of-range requests are consumed (ready stays honest) but never queued.
  assign in_range = int'(bus.i_req_addr) < TOTAL_OPTIONS;
  assign accept   = bus.i_req_valid && !full;
  assign push     = accept && in_range;
  assign pop      = (state == IDLE) && !empty;

  dac_addr_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.i_req_addr),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Handshake FSM: IDLE pops, ISSUE holds the address until ack/timeout,
  // RELEASE keeps ready low so the router can return to idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      addr_q       <= '0;
      addr_ready_q <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      rel_cnt      <= '0;
`ifdef DAC_SEQ_TIMEOUT_EN
      to_cnt       <= '0;
`endif
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            addr_q       <= fifo_dout;
            addr_ready_q <= 1'b1;
            state        <= ISSUE;
`ifdef DAC_SEQ_TIMEOUT_EN
            to_cnt       <= '0;
`endif
          end
        end
        ISSUE: begin
          // Ack has priority over a timeout landing in the same cycle.
          if (bus.i_ack_in) begin
            addr_ready_q <= 1'b0;
            done_q       <= 1'b1;
            rel_cnt      <= '0;
            state        <= RELEASE;
          end
`ifdef DAC_SEQ_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            addr_ready_q <= 1'b0;
            timeout_q    <= 1'b1;
            rel_cnt      <= '0;
            state        <= RELEASE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        RELEASE: begin
          if (rel_cnt == REL_LAST) state <= IDLE;
          else                     rel_cnt <= rel_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-cycle pulse for a dropped out-of-range request.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) err_q <= 1'b0;
    else       err_q <= accept && !in_range;
  end

  assign bus.o_req_ready  = !full;
  assign bus.o_addr_out   = addr_q;
  assign bus.o_addr_ready = addr_ready_q;
  assign bus.o_done       = done_q;
  assign bus.o_timeout    = timeout_q;
  assign bus.o_err_addr   = err_q;
  assign bus.o_busy       = (state != IDLE) || !empty;
  assign bus.o_fifo_count = count;
endmodule

// File: tb/tb_dac_addr_sequencer.sv
// Scoreboard bench for dac_addr_sequencer: directed scenarios plus random
// traffic; a negedge monitor checks the DUT against a queue-based model.
module tb_dac_addr_sequencer;
  localparam int VS    = 4;
  localparam int TOT   = 24;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int TO    = 255;
  localparam int CW    = 3;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dac_addr_sequencer_if #(.ADDR_WIDTH(AW), .CNT_W(CW)) bus ();

  dac_addr_sequencer #(
    .VECTOR_SIZE    (VS),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.master)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + monitor ----------------
  // Expected issue order: every accepted in-range address, visible for
  // issue two negedges after the monitor saw it offered.
  typedef struct {
    logic [AW-1:0] addr;
    int            vis;
  } ent_t;

  ent_t          exp_q[$];
  int            cyc = 0;
  int            hi_run = 0;
  int            low_run = 3;
  logic          prev_ready = 1'b0;
  logic          prev_ack = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic          err_pend = 1'b0;
  logic          ack_end, to_end, rise_exp, acc;

  always @(negedge i_clk) begin
    cyc++;
    if (i_rst) begin
      exp_q.delete();
      hi_run     = 0;
      low_run    = 3;
      prev_ready = 1'b0;
      prev_ack   = 1'b0;
      err_pend   = 1'b0;
    end else begin
      ack_end = prev_ready && prev_ack;
      to_end  = 1'b0;
`ifdef DAC_SEQ_TIMEOUT_EN
      to_end  = prev_ready && !prev_ack && (hi_run == TO);
`endif
      if (ack_end || bus.o_done)    chk("done_pulse", int'(bus.o_done), int'(ack_end));
      if (to_end || bus.o_timeout)  chk("timeout_pulse", int'(bus.o_timeout), int'(to_end));
      if (prev_ready) begin
        if (ack_end || to_end) chk("ready_drop", int'(bus.o_addr_ready), 0);
        else begin
          chk("ready_hold", int'(bus.o_addr_ready), 1);
          chk("addr_stable", int'(bus.o_addr_out), int'(prev_addr));
        end
      end else begin
        // A new ISSUE needs 3 low cycles (2 release + 1 idle) and a ready entry.
        rise_exp = (low_run >= 3) && (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
        chk("issue_start", int'(bus.o_addr_ready), int'(rise_exp));
        if (rise_exp) begin
          if (bus.o_addr_ready) chk("issue_addr", int'(bus.o_addr_out), int'(exp_q[0].addr));
          void'(exp_q.pop_front());
        end
      end
      chk("fifo_count", int'(bus.o_fifo_count), exp_q.size());
      chk("req_ready", int'(bus.o_req_ready), int'(exp_q.size() < DEPTH));
      if (err_pend || bus.o_err_addr) chk("err_addr", int'(bus.o_err_addr), int'(err_pend));

      acc      = bus.i_req_valid && (exp_q.size() < DEPTH);
      err_pend = acc && (int'(bus.i_req_addr) >= TOT);
      if (acc && int'(bus.i_req_addr) < TOT) exp_q.push_back('{bus.i_req_addr, cyc + 2});

      if (bus.o_addr_ready) begin
        hi_run++;
        low_run = 0;
      end else begin
        hi_run = 0;
        if (low_run < 100) low_run++;
      end
      prev_ready = bus.o_addr_ready;
      prev_ack   = bus.i_ack_in;
      prev_addr  = bus.o_addr_out;
    end
  end

  // ---------------- stimulus ----------------
  // Inputs change 2 time units after the rising edge and apply at the next one.
  task automatic step(input logic v, input logic [AW-1:0] a, input logic k);
    @(posedge i_clk);
    #2;
    bus.i_req_valid = v;
    bus.i_req_addr  = a;
    bus.i_ack_in    = k;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  // Random acks until the DUT goes quiet, bounded by budget.
  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      step(1'b0, '0, ($urandom_range(0, 2) == 0));
      if (!bus.o_busy) break;
    end
    chk("drain_idle", int'(bus.o_busy), 0);
    step(1'b0, '0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.i_req_valid = 1'b0;
    bus.i_req_addr  = '0;
    bus.i_ack_in    = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_addr_ready", int'(bus.o_addr_ready), 0);
    chk("rst_addr_out", int'(bus.o_addr_out), 0);
    chk("rst_done", int'(bus.o_done), 0);
    chk("rst_timeout", int'(bus.o_timeout), 0);
    chk("rst_err", int'(bus.o_err_addr), 0);
    chk("rst_busy", int'(bus.o_busy), 0);
    chk("rst_count", int'(bus.o_fifo_count), 0);
    chk("rst_req_ready", int'(bus.o_req_ready), 1);
    @(posedge i_clk);
    #2 i_rst = 1'b0;

    // Single transfer: push 5, ack at the third edge after the push.
    step(1'b1, 5'd5, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("single_ready", int'(bus.o_addr_ready), 1);
    chk("single_addr", int'(bus.o_addr_out), 5);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    chk("single_done", int'(bus.o_done), 1);
    chk("single_drop", int'(bus.o_addr_ready), 0);
    drain(20);

    // Queue ordering and full: 1 issues, 2..5 fill the queue, 6 is refused.
    for (int i = 1; i <= 5; i++) step(1'b1, AW'(i), 1'b0);
    step(1'b1, 5'd6, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("full_count", int'(bus.o_fifo_count), DEPTH);
    chk("full_ready", int'(bus.o_req_ready), 0);
    drain(300);

    // Out-of-range address is dropped with an error pulse.
    step(1'b1, 5'd24, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("oor_err", int'(bus.o_err_addr), 1);
    chk("oor_count", int'(bus.o_fifo_count), 0);
    step(1'b0, '0, 1'b0);
    chk("oor_no_issue", int'(bus.o_addr_ready), 0);
    chk("oor_busy", int'(bus.o_busy), 0);

`ifdef DAC_SEQ_TIMEOUT_EN
    // Timeout: 7 is abandoned, then 8 issues.
    step(1'b1, 5'd7, 1'b0);
    step(1'b1, 5'd8, 1'b0);
    idle(TO + 20);
    chk("to_next_addr", int'(bus.o_addr_out), 8);
    drain(1000);

    // Ack lands in the last timeout cycle: done wins.
    step(1'b1, 5'd9, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("coll_ready", int'(bus.o_addr_ready), 1);
    idle(TO - 2);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    chk("coll_done", int'(bus.o_done), 1);
    chk("coll_timeout", int'(bus.o_timeout), 0);
    drain(20);
`else
    // Without the timeout, ISSUE waits indefinitely.
    step(1'b1, 5'd7, 1'b0);
    idle(TO + 50);
    chk("noto_ready", int'(bus.o_addr_ready), 1);
    chk("noto_addr", int'(bus.o_addr_out), 7);
    drain(50);
`endif

    // Reset mid-ISSUE with two entries queued.
    step(1'b1, 5'd10, 1'b0);
    step(1'b1, 5'd11, 1'b0);
    step(1'b1, 5'd12, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("pre_rst_ready", int'(bus.o_addr_ready), 1);
    chk("pre_rst_count", int'(bus.o_fifo_count), 2);
    i_rst = 1'b1;
    #1;
    chk("midrst_ready", int'(bus.o_addr_ready), 0);
    chk("midrst_count", int'(bus.o_fifo_count), 0);
    chk("midrst_busy", int'(bus.o_busy), 0);
    chk("midrst_req_ready", int'(bus.o_req_ready), 1);
    chk("midrst_addr", int'(bus.o_addr_out), 0);
    @(posedge i_clk);
    #2 i_rst = 1'b0;

    // Random traffic, including out-of-range addresses and stray acks.
    for (int i = 0; i < 800; i++)
      step(($urandom_range(0, 1) == 1), AW'($urandom_range(0, 31)), ($urandom_range(0, 2) == 0));
    step(1'b0, '0, 1'b0);
    drain(2000);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
